storage_arbiter: RTL and testbench
==================================

STORAGE_ARBITER -- requirements
Module: storage_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of the four-register storage being driven.
REQ-002 Parameter NUM_REQ, default 2, number of requesters; legal range 2..4.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ  input  NUM_REQ  per-requester write request, level.
REQ-006 REQ_ADDR  input  2*NUM_REQ  per-requester target; 0=A, 1=B, 2=C, 3=D; requester i uses bits [2i+1:2i].
REQ-007 REQ_DATA  input  WIDTH*NUM_REQ  per-requester write data; requester i uses slice i.
REQ-008 ACK  output  NUM_REQ  one-cycle completion pulse per requester.
REQ-009 BUSY  output  1  high while a write or init sweep is in progress.
REQ-010 WRITE_ENB  output  1  write strobe to storage.
REQ-011 SEL_AB  output  1  storage bank select.
REQ-012 SEL_A  output  1  storage register select.
REQ-013 DATA  output  WIDTH  write data to storage.

Function
REQ-014 Address decode SHALL be: A -> SEL_AB=1,SEL_A=1; B -> 1,0; C -> 0,1; D -> 0,0.
REQ-015 FSM states SHALL be INIT, IDLE, SETUP, STROBE, HOLD; all storage-side outputs registered, glitch-free.
REQ-016 IDLE: if any REQ high, grant one requester round-robin, latch its address and data, go to SETUP; else stay IDLE.
REQ-017 SETUP: SEL_AB/SEL_A/DATA driven from latched values, WRITE_ENB=0; next STROBE.
REQ-018 STROBE: WRITE_ENB=1 for exactly one cycle, selects and DATA unchanged; next HOLD.
REQ-019 HOLD: WRITE_ENB=0, selects and DATA held; ACK[granted]=1 for this cycle only; next IDLE.
REQ-020 One write SHALL take 4 cycles from grant (IDLE) to ACK (HOLD) inclusive; next grant earliest in the following IDLE cycle.
REQ-021 Round-robin: after granting i, priority starts at i+1 mod NUM_REQ; after reset the pointer is 0.
REQ-022 Address and data SHALL be sampled only at grant; later changes to REQ_ADDR/REQ_DATA or REQ deassertion do not alter or abort the write, and ACK is still issued.
REQ-023 A requester holding REQ high after its ACK SHALL be treated as a new request.
REQ-024 BUSY SHALL be 1 in INIT, SETUP, STROBE and HOLD, and 0 in IDLE.
REQ-025 DATA and selects SHALL retain their last values in IDLE.
REQ-026 At most one ACK bit SHALL be high in any cycle.

Reset
REQ-027 RST asserted SHALL asynchronously force WRITE_ENB=0, SEL_AB=0, SEL_A=0, DATA=0, ACK=0 and the round-robin pointer to 0.
REQ-028 Reset mid-write SHALL drop WRITE_ENB immediately; the interrupted write is not retried and no ACK is issued.
REQ-029 After reset the FSM SHALL enter INIT when STORAGE_ARB_INIT_EN is defined and IDLE otherwise; BUSY reset value is 1 and 0 respectively.

Configuration
REQ-030 Macro STORAGE_ARB_INIT_EN defined: INIT SHALL write 0 to A, B, C, D in that order, each using the SETUP/STROBE/HOLD timing, with no ACK; INIT takes 12 cycles, and requests wait, then are served from IDLE.
REQ-031 Macro STORAGE_ARB_INIT_EN undefined: the INIT state and sweep counter SHALL be absent, and the first request is granted on the first cycle after reset release.

Structure
REQ-032 Shared package storage_arb_pkg SHALL hold the FSM state enum, the address constants ADDR_A..ADDR_D, and the address-to-select decode function.
REQ-033 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-034 Single write: REQ[0]=1, ADDR=2, DATA=0x5A -> SEL_AB=0, SEL_A=1, DATA=0x5A in SETUP; WRITE_ENB high one cycle; ACK[0] pulse 3 cycles after grant.
REQ-035 Contention: REQ=2'b11 held continuously -> grants alternate 0,1,0,1; ACKs every 4 cycles; never two ACKs in the same cycle.
REQ-036 Late change: after grant, flip REQ_DATA to 0xFF and drop REQ -> storage receives the original value; ACK still pulses.
REQ-037 Reset mid-write: assert RST during STROBE -> WRITE_ENB=0 within the same cycle; no ACK; outputs all 0.
REQ-038 Init (STORAGE_ARB_INIT_EN): release reset with REQ[1]=1 -> four zero writes A..D (12 cycles, BUSY=1), then requester 1 is granted.
REQ-039 Decode sweep: writes 0x11,0x22,0x33,0x44 to addresses 0..3 -> the selects follow REQ-014 for each write, and the storage reads back A=0x11, B=0x22, C=0x33, D=0x44.

Source files
------------

// File: rtl/storage_arb_pkg.sv
// Shared types for the storage arbiter: FSM states, storage addresses
// and the address-to-select decode used to drive the register file.
package storage_arb_pkg;

`ifdef STORAGE_ARB_INIT_EN
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;
`endif

    localparam logic [1:0] ADDR_A = 2'd0;
    localparam logic [1:0] ADDR_B = 2'd1;
    localparam logic [1:0] ADDR_C = 2'd2;
    localparam logic [1:0] ADDR_D = 2'd3;

    // Returns {sel_ab, sel_a} for a storage address.
    function automatic logic [1:0] addr_decode(input logic [1:0] addr);
        logic [1:0] sel;
        sel = 2'b00;
        unique case (addr)
            ADDR_A: sel = 2'b11;
            ADDR_B: sel = 2'b10;
            ADDR_C: sel = 2'b01;
            ADDR_D: sel = 2'b00;
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches req starting at ptr, wrapping at NUM_REQ.
// Ports: req (request vector), ptr (first index to try), grant (one-hot).
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/storage_arbiter.sv
// Arbitrates NUM_REQ writers onto a four-register storage with registered
// SETUP/STROBE/HOLD write timing. Optional macro STORAGE_ARB_INIT_EN adds
// a reset-time sweep that zeroes A..D before requests are served.
// Ports: CLK, RST (async active-high), REQ/REQ_ADDR/REQ_DATA (requesters),
// ACK (completion pulse), BUSY, WRITE_ENB/SEL_AB/SEL_A/DATA (storage side).
module storage_arbiter
    import storage_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       REQ,
    input  logic [2*NUM_REQ-1:0]     REQ_ADDR,
    input  logic [WIDTH*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]       ACK,
    output logic                     BUSY,
    output logic                     WRITE_ENB,
    output logic                     SEL_AB,
    output logic                     SEL_A,
    output logic [WIDTH-1:0]         DATA
);

    localparam logic [1:0] LAST = 2'(NUM_REQ - 1);

`ifdef STORAGE_ARB_INIT_EN
    localparam state_t RST_STATE = ST_INIT;
    localparam logic   RST_BUSY  = 1'b1;
`else
    localparam state_t RST_STATE = ST_IDLE;
    localparam logic   RST_BUSY  = 1'b0;
`endif

    state_t             state;
    logic [1:0]         ptr;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] gnt_q;
    logic [1:0]         gidx;
    logic [1:0]         gaddr;
    logic [WIDTH-1:0]   gdata;

`ifdef STORAGE_ARB_INIT_EN
    logic [1:0] sweep;
    logic [1:0] phase;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req  (REQ),
        .ptr  (ptr),
        .grant(grant)
    );

    always_comb begin
        gidx = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gidx = 2'(i);
        end
    end

    assign gaddr = REQ_ADDR[2*int'(gidx) +: 2];
    assign gdata = REQ_DATA[WIDTH*int'(gidx) +: WIDTH];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RST_STATE;
            BUSY      <= RST_BUSY;
            WRITE_ENB <= 1'b0;
            SEL_AB    <= 1'b0;
            SEL_A     <= 1'b0;
            DATA      <= '0;
            ACK       <= '0;
            ptr       <= 2'd0;
            gnt_q     <= '0;
`ifdef STORAGE_ARB_INIT_EN
            sweep     <= 2'd0;
            phase     <= 2'd0;
`endif
        end else begin
            ACK <= '0;
            unique case (state)
`ifdef STORAGE_ARB_INIT_EN
                // Each zero write: load selects, strobe, drop strobe.
                // The last write's hold cycle is the first IDLE cycle.
                ST_INIT: begin
                    unique case (phase)
                        2'd0: begin
                            {SEL_AB, SEL_A} <= addr_decode(sweep);
                            DATA  <= '0;
                            phase <= 2'd1;
                        end
                        2'd1: begin
                            WRITE_ENB <= 1'b1;
                            phase     <= 2'd2;
                        end
                        default: begin
                            WRITE_ENB <= 1'b0;
                            phase     <= 2'd0;
                            sweep     <= sweep + 2'd1;
                            if (sweep == ADDR_D) begin
                                state <= ST_IDLE;
                                BUSY  <= 1'b0;
                            end
                        end
                    endcase
                end
`endif
                ST_IDLE: begin
                    if (|REQ) begin
                        {SEL_AB, SEL_A} <= addr_decode(gaddr);
                        DATA  <= gdata;
                        gnt_q <= grant;
                        ptr   <= (gidx == LAST) ? 2'd0 : gidx + 2'd1;
                        BUSY  <= 1'b1;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    WRITE_ENB <= 1'b1;
                    state     <= ST_STROBE;
                end
                ST_STROBE: begin
                    WRITE_ENB <= 1'b0;
                    ACK       <= gnt_q;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_storage_arbiter.sv
// Directed bench for storage_arbiter with a behavioural four-register
// storage attached to the write port.
module tb_storage_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] REQ = '0;
    logic [3:0] REQ_ADDR = '0;
    logic [15:0] REQ_DATA = '0;
    logic [1:0] ACK;
    logic       BUSY;
    logic       WRITE_ENB;
    logic       SEL_AB;
    logic       SEL_A;
    logic [7:0] DATA;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [4] = '{default: 8'hEE};
    logic [1:0] sel_tab [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
    logic [1:0] ack_or;

    storage_arbiter #(.WIDTH(8), .NUM_REQ(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .REQ_ADDR (REQ_ADDR),
        .REQ_DATA (REQ_DATA),
        .ACK      (ACK),
        .BUSY     (BUSY),
        .WRITE_ENB(WRITE_ENB),
        .SEL_AB   (SEL_AB),
        .SEL_A    (SEL_A),
        .DATA     (DATA)
    );

    always #5 CLK = ~CLK;

    // Storage: A=0, B=1, C=2, D=3 from the select lines.
    always @(posedge CLK) begin
        if (WRITE_ENB) mem[{~SEL_AB, ~SEL_A}] <= DATA;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        check("rst_we", 32'(WRITE_ENB), 0);
        check("rst_sel", 32'({SEL_AB, SEL_A}), 0);
        check("rst_data", 32'(DATA), 0);
        check("rst_ack", 32'(ACK), 0);
`ifdef STORAGE_ARB_INIT_EN
        check("rst_busy", 32'(BUSY), 1);
`else
        check("rst_busy", 32'(BUSY), 0);
`endif
        tick();
        RST = 1'b0;

`ifdef STORAGE_ARB_INIT_EN
        REQ = 2'b10;
        REQ_ADDR = 4'b0100;
        REQ_DATA = 16'h9900;
        for (int c = 0; c < 12; c++) begin
            check("init_busy", 32'(BUSY), 1);
            check("init_ack", 32'(ACK), 0);
            tick();
        end
        check("init_idle", 32'(BUSY), 0);
        for (int a = 0; a < 4; a++) check("init_mem", 32'(mem[a]), 0);
        tick();
        check("init_grant_sel", 32'({SEL_AB, SEL_A}), 2'b10);
        check("init_grant_data", 32'(DATA), 8'h99);
        tick();
        tick();
        check("init_ack1", 32'(ACK), 2'b10);
        REQ = 2'b00;
        tick();
        do_reset();
`endif

        // Single write: requester 0, address C, 0x5A
        REQ = 2'b01;
        REQ_ADDR = 4'b0010;
        REQ_DATA = 16'h005A;
        tick();
        check("sw_sel", 32'({SEL_AB, SEL_A}), 2'b01);
        check("sw_data", 32'(DATA), 8'h5A);
        check("sw_we_setup", 32'(WRITE_ENB), 0);
        check("sw_busy", 32'(BUSY), 1);
        tick();
        check("sw_we_strobe", 32'(WRITE_ENB), 1);
        check("sw_ack_strobe", 32'(ACK), 0);
        tick();
        check("sw_we_hold", 32'(WRITE_ENB), 0);
        check("sw_ack", 32'(ACK), 2'b01);
        REQ = 2'b00;
        tick();
        check("sw_ack_off", 32'(ACK), 0);
        check("sw_idle_busy", 32'(BUSY), 0);
        check("sw_idle_data", 32'(DATA), 8'h5A);
        check("sw_mem", 32'(mem[2]), 8'h5A);

        // Contention from a fresh pointer: grants 0,1,0,1
        do_reset();
        REQ = 2'b11;
        REQ_ADDR = 4'b0100;
        REQ_DATA = 16'hB1A0;
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            tick();
            check("ct_ack", 32'(ACK), (k % 2 == 0) ? 2'b01 : 2'b10);
            check("ct_data", 32'(DATA), (k % 2 == 0) ? 8'hA0 : 8'hB1);
            tick();
            check("ct_ack_gap", 32'(ACK), 0);
        end
        REQ = 2'b00;
        tick();
        check("ct_mem_a", 32'(mem[0]), 8'hA0);
        check("ct_mem_b", 32'(mem[1]), 8'hB1);

        // Late change after grant
        REQ = 2'b01;
        REQ_ADDR = 4'b0011;
        REQ_DATA = 16'h003C;
        tick();
        REQ = 2'b00;
        REQ_ADDR = 4'b0000;
        REQ_DATA = 16'h00FF;
        check("lc_data", 32'(DATA), 8'h3C);
        tick();
        tick();
        check("lc_ack", 32'(ACK), 2'b01);
        tick();
        check("lc_mem_d", 32'(mem[3]), 8'h3C);
        check("lc_mem_a", 32'(mem[0]), 8'hA0);

        // Reset during STROBE
        REQ = 2'b10;
        REQ_ADDR = 4'b0100;
        REQ_DATA = 16'h7700;
        tick();
        tick();
        check("rm_we_strobe", 32'(WRITE_ENB), 1);
        #1 RST = 1'b1;
        #1;
        check("rm_we", 32'(WRITE_ENB), 0);
        check("rm_sel", 32'({SEL_AB, SEL_A}), 0);
        check("rm_data", 32'(DATA), 0);
        tick();
        RST = 1'b0;
        REQ = 2'b00;
        ack_or = '0;
        for (int c = 0; c < 4; c++) begin
            ack_or |= ACK;
            tick();
        end
        check("rm_no_ack", 32'(ack_or), 0);
        check("rm_mem_b", 32'(mem[1]), 8'hB1);
        check("rm_busy", 32'(BUSY), 0);

        // Decode sweep
        for (int a = 0; a < 4; a++) begin
            REQ = 2'b01;
            REQ_ADDR = 4'(a);
            REQ_DATA = 16'(8'h11 * (a + 1));
            tick();
            check("dec_sel", 32'({SEL_AB, SEL_A}), 32'(sel_tab[a]));
            tick();
            tick();
            check("dec_ack", 32'(ACK), 2'b01);
            REQ = 2'b00;
            tick();
        end
        check("dec_mem_a", 32'(mem[0]), 8'h11);
        check("dec_mem_b", 32'(mem[1]), 8'h22);
        check("dec_mem_c", 32'(mem[2]), 8'h33);
        check("dec_mem_d", 32'(mem[3]), 8'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
